counter_mod_updown: RTL

Parametrised modulo-N up/down counter: the next generation of the team's basic modulo counter. It adds a direction control, parallel load, selectable wrap or saturate behaviour, a combinational terminal-count output for cascading digits, a sticky overflow flag and a saturating boundary-event counter. It is intended for use in timers, prescalers and multi-digit BCD/time-of-day chains, where instances are cascaded by feeding one stage's `tc` into the next stage's `ce`.

---
 rtl/counter_mod_updown.sv | 76 +++++++
 1 files changed

// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with load, wrap/saturate, cascade terminal count, sticky overflow and event count.
// out/ovf/events update one edge after a sampled command; tc is combinational; no backpressure, one step per cycle.
module counter_mod_updown #(
  parameter int MODULO    = 10,
  parameter int WIDTH     = $clog2(MODULO),
  parameter int SATURATE  = 0,
  parameter int EVT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 up,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clr,
  output logic [WIDTH-1:0]     out,
  output logic                 tc,
  output logic                 ovf,
  output logic [EVT_WIDTH-1:0] events
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic                 at_top;
  logic                 at_bot;
  logic                 din_big;
  logic                 ovf_set;
  logic [WIDTH-1:0]     nxt_out;
  logic                 nxt_ovf;
  logic [EVT_WIDTH-1:0] ev_base;
  logic [EVT_WIDTH-1:0] nxt_events;

  assign at_top  = (out == MAX);
  assign at_bot  = (out == '0);
  assign din_big = (din > MAX);

  // tc marks exactly the cycles whose edge performs a boundary event, so it drives both cascading and the flags.
  assign tc      = rst & ce & ~load & ((up & at_top) | (~up & at_bot));
  assign ovf_set = tc | (load & din_big);

  always_comb begin
    nxt_out = out;
    if (load) begin
      nxt_out = din_big ? MAX : din;
    end else if (ce) begin
      if (tc) begin
        if (SATURATE == 0) nxt_out = up ? '0 : MAX;
      end else if (up) begin
        nxt_out = out + WIDTH'(1);
      end else begin
        nxt_out = out - WIDTH'(1);
      end
    end
  end

  // Clear applies first so a coincident boundary event leaves events at exactly one.
  always_comb begin
    nxt_ovf    = ovf_set | (ovf & ~clr);
    ev_base    = clr ? '0 : events;
    nxt_events = ev_base;
    if (tc && (ev_base != {EVT_WIDTH{1'b1}})) nxt_events = ev_base + EVT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out    <= '0;
      ovf    <= 1'b0;
      events <= '0;
    end else begin
      out    <= nxt_out;
      ovf    <= nxt_ovf;
      events <= nxt_events;
    end
  end

endmodule
